// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage types and constants for the OpenMIPS IF stage.
package if_fetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic [INST_W-1:0]      ZERO_WORD  = '0;
    localparam logic                   RST_ENABLE = 1'b0;
    localparam logic [INST_ADDR_W-1:0] INST_STEP  = 32'd4;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] a);
        return {a[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Small circular FIFO with flush; head word is read straight from storage.
module fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned W     = ENTRY_W,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [CW-1:0] count_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_pop    = pop & ~empty;
        do_push   = push & (~full | do_pop);
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= ptr_inc(wr_ptr);
                end
                if (do_pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
            end
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// OpenMIPS instruction fetch: credit-limited in-order issue, response buffering,
// and wrong-path discard on redirect.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned            DEPTH    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [INST_ADDR_W-1:0] imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INST_W-1:0]      imem_rdata,
    input  logic                   redirect_i,
    input  logic [INST_ADDR_W-1:0] redirect_pc_i,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic [INST_ADDR_W-1:0] pc;
    logic [CW-1:0]          out_cnt;
    logic [CW-1:0]          kill_cnt;
    logic                   fetch_en;

    logic [CW-1:0]          fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [CW-1:0]          pend_count;
    logic                   pend_empty;
    logic                   pend_full;
    logic [INST_ADDR_W-1:0] pend_pc;
    fetch_entry_t           inst_din;
    fetch_entry_t           inst_head;

    logic                   pop;
    logic                   grant;
    logic                   resp;
    logic                   push_inst;
    logic [SW-1:0]          credit_used;

    // fetch_en keeps imem_req low through reset without a reset-to-output path.
    always_comb begin
        pop         = ~fifo_empty & if_ready;
        credit_used = SW'(out_cnt) + SW'(fifo_count) - SW'(pop);
        imem_req    = fetch_en & ~redirect_i & (credit_used < SW'(DEPTH));
        imem_addr   = word_align(pc);
        grant       = imem_req & imem_gnt;
        resp        = imem_rvalid & (out_cnt != '0);
        push_inst   = resp & ~redirect_i & (kill_cnt == '0);
        inst_din    = '{pc: pend_pc, inst: imem_rdata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            pc       <= RESET_PC;
            out_cnt  <= '0;
            kill_cnt <= '0;
            fetch_en <= 1'b0;
        end else begin
            fetch_en <= 1'b1;
            out_cnt  <= out_cnt + CW'(grant) - CW'(resp);
            if (redirect_i) begin
                pc       <= word_align(redirect_pc_i);
                kill_cnt <= out_cnt - CW'(resp);
            end else begin
                if (grant) begin
                    pc <= pc + INST_STEP;
                end
                if (resp && (kill_cnt != '0)) begin
                    kill_cnt <= kill_cnt - CW'(1);
                end
            end
        end
    end

    // Instruction buffer: {pc, inst} pairs presented to IF/ID.
    fetch_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_inst_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_inst),
        .pop   (pop & ~redirect_i),
        .flush (redirect_i),
        .din   (inst_din),
        .dout  (inst_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Pending-PC queue: survives redirects so killed responses still retire in order.
    fetch_fifo #(.DEPTH(DEPTH), .W(INST_ADDR_W)) u_pend_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .pop   (resp),
        .flush (1'b0),
        .din   (imem_addr),
        .dout  (pend_pc),
        .count (pend_count),
        .empty (pend_empty),
        .full  (pend_full)
    );

    assign if_valid = ~fifo_empty;
    assign if_pc    = inst_head.pc;
    assign if_inst  = inst_head.inst;

    always @(posedge clk) begin
        if (rst != RST_ENABLE) begin
            assert (!(imem_rvalid && (out_cnt == '0)));
            assert (pend_count == out_cnt);
            assert (!(grant && pend_full));
            assert (!(resp && pend_empty));
            assert (!(push_inst && fifo_full && !pop));
        end
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit for the OpenMIPS five-stage pipeline. It drives the IF side of the IF/ID pipeline register. It generates the sequential PC and issues in-order requests to instruction memory. Returned words are buffered together with their PC, and on a branch/exception redirect it discards wrong-path instructions, including responses still in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, credit limit: maximum of outstanding requests plus buffered instructions

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_gnt  in  1  request accepted this cycle (meaningful only with imem_req)
- imem_rvalid  in  1  response valid; responses return in request order
- imem_rdata  in  32  instruction word
- redirect_i  in  1  branch taken or exception/flush
- redirect_pc_i  in  32  new fetch address
- if_valid  out  1  if_pc/if_inst hold a valid instruction
- if_ready  in  1  IF/ID accepts (not stalled); transfer when if_valid & if_ready
- if_pc  out  32  PC of head instruction
- if_inst  out  32  head instruction word

## Operation
- State: pc (32b), out_cnt (outstanding requests, 0..DEPTH), kill_cnt (responses to discard, 0..DEPTH), FIFO of {pc, inst}, DEPTH entries.
- Reset values: pc=RESET_PC, out_cnt=0, kill_cnt=0, FIFO empty. Outputs: if_valid=0, if_pc=0, if_inst=0, imem_req=0 while rst=0.
- pop = if_valid & if_ready.
- Issue: imem_req = ~redirect_i & (out_cnt + fifo_count - pop < DEPTH). imem_addr = {pc[31:2],2'b00}.
- On imem_req & imem_gnt:
  - pc <= pc + 4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
  - out_cnt increments.
  - The issued address is pushed into the pending-PC queue (DEPTH entries).
- Response: on imem_rvalid, out_cnt decrements and the head pending PC is popped.
  - kill_cnt > 0: the response is dropped and kill_cnt decrements.
  - Otherwise: {pending PC, imem_rdata} is pushed into the FIFO.
- Redirect (redirect_i=1):
  - pc <= {redirect_pc_i[31:2],2'b00}; low two bits ignored.
  - FIFO cleared; any pop that cycle is still honoured by the consumer, but the entry is discarded.
  - kill_cnt <= out_cnt − (imem_rvalid ? 1 : 0).
  - No request is issued that cycle.
- Redirect in the same cycle as rvalid: that response is dropped regardless of kill_cnt.
- Simultaneous push and pop of the FIFO is legal at any count.
- imem_rvalid with out_cnt=0 is a protocol error; an assertion fires and state is unchanged.

## Timing
- Earliest path, request to output: request granted in cycle N, rvalid in N+1, if_valid=1 in N+2.
- Sustains one instruction per cycle with 1-cycle memory latency and if_ready held high.
- if_ready=0: the head entry is held stable and issue stops once credits are exhausted.
- Redirect in cycle N: imem_req=0 in N; first new-path request appears in N+1 with imem_addr=redirect target.
- Asynchronous reset mid-operation clears everything immediately. imem must share rst so that no stale responses return afterwards.
- There are two combinational paths: if_ready→imem_req and redirect_i→imem_req. No other input→output combinational paths exist.

## Structure
- Shared define.v: `InstAddrBus`, `InstBus`, `ZeroWord`; add `RstEnable` = 1'b0 for the active-low reset, and `InstStep` = 32'd4.
- Sub-module fetch_fifo:
  - DEPTH-entry {pc, inst} FIFO with push, pop, flush, count, and empty/full flags.
  - Used for the instruction buffer; a second narrow instance serves as the pending-PC queue.
- Top level holds pc, out_cnt, kill_cnt and the issue logic.

## Test plan
- Reset release, memory latency 1, if_ready=1 → imem_addr sequence 0x0, 0x4, 0x8…; if_pc 0x0 appears 2 cycles after the first grant, then one per cycle with if_inst matching.
- if_ready=0 for 5 cycles after the first output → if_pc=0x0 held; at most 2 requests issued in total; streaming resumes at 0x4 when released.
- Two requests outstanding (0x8, 0xC) with latency 3, redirect to 0x100 → both responses dropped; next if_pc=0x100; kill_cnt returns to 0.
- Redirect in the same cycle as rvalid for 0x4 → 0x4 is never presented; next output is the redirect target.
- Redirect to 0xFFFF_FFF8 (and to 0x203 → fetches 0x200) → outputs 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0.
- Assert rst mid-stream with a full FIFO → all outputs are 0 immediately; after release, fetch restarts at RESET_PC.
